btn_debouncer: RTL

BTN_DEBOUNCER -- requirements
Module: btn_debouncer

---
 rtl/btn_debouncer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/btn_debouncer.sv
// Debounces NUM_BTN asynchronous buttons, sampled on rising edges of a slow sample_clk.
// Latency: sample_tick 3 cycles after a sample_clk rise; level/press change on the STABLE_COUNT-th agreeing tick.
// Backpressure: none, outputs are free-running registered levels and pulses.
module btn_debouncer #(
    parameter int NUM_BTN      = 4,
    parameter int STABLE_COUNT = 4
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               sample_clk,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               sample_tick
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LAST = 3'(STABLE_COUNT - 1);

    logic               smp_s1;
    logic               smp_s2;
    logic               smp_hist;
    logic               armed;
    logic [1:0]         fill;
    logic [NUM_BTN-1:0] raw_s1;
    logic [NUM_BTN-1:0] raw_s2;
    state_t             state [NUM_BTN];
    logic [2:0]         cnt   [NUM_BTN];
    logic               tick;

    // armed stays low until a genuine low level has passed the synchronizer,
    // so a sample_clk already high at reset release cannot fake a rising edge.
    assign tick = smp_s2 & ~smp_hist & armed;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            smp_s1      <= 1'b0;
            smp_s2      <= 1'b0;
            smp_hist    <= 1'b0;
            armed       <= 1'b0;
            fill        <= 2'd0;
            raw_s1      <= '0;
            raw_s2      <= '0;
            sample_tick <= 1'b0;
        end else begin
            smp_s1      <= sample_clk;
            smp_s2      <= smp_s1;
            smp_hist    <= smp_s2;
            raw_s1      <= btn_raw;
            raw_s2      <= raw_s1;
            sample_tick <= tick;
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd2 && !smp_s2) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            btn_level <= '0;
            btn_press <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= 3'd0;
            end
        end else begin
            btn_press <= '0;
            if (tick) begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    unique case (state[i])
                        IDLE: begin
                            if (raw_s2[i]) begin
                                state[i] <= PRESS_WAIT;
                                cnt[i]   <= 3'd1;
                            end else begin
                                cnt[i]   <= 3'd0;
                            end
                        end
                        PRESS_WAIT: begin
                            if (!raw_s2[i]) begin
                                state[i] <= IDLE;
                                cnt[i]   <= 3'd0;
                            end else if (cnt[i] == CNT_LAST) begin
                                state[i]     <= PRESSED;
                                cnt[i]       <= 3'd0;
                                btn_level[i] <= 1'b1;
                                btn_press[i] <= 1'b1;
                            end else begin
                                cnt[i]   <= cnt[i] + 3'd1;
                            end
                        end
                        PRESSED: begin
                            if (!raw_s2[i]) begin
                                state[i] <= RELEASE_WAIT;
                                cnt[i]   <= 3'd1;
                            end
                        end
                        RELEASE_WAIT: begin
                            if (raw_s2[i]) begin
                                state[i] <= PRESSED;
                                cnt[i]   <= 3'd0;
                            end else if (cnt[i] == CNT_LAST) begin
                                state[i]     <= IDLE;
                                cnt[i]       <= 3'd0;
                                btn_level[i] <= 1'b0;
                            end else begin
                                cnt[i]   <= cnt[i] + 3'd1;
                            end
                        end
                        default: begin
                            state[i] <= IDLE;
                            cnt[i]   <= 3'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
